// File: rtl/game_pkg.sv
// Shared types and constants for the game sequencing blocks.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_SPAWNING,
    ST_PLAYING,
    ST_DONE
  } level_state_t;

  localparam int DEFAULT_ENEMY_BIKES = 16;
  localparam int SCORE_W             = 16;

endpackage

// File: rtl/spawn_scheduler.sv
// Staggers one-hot enemy spawn pulses: bike 0 on start, then one bike every
// SPAWN_INTERVAL ticks until bikes_i bikes have been released.
module spawn_scheduler #(
  parameter int N              = 16,
  parameter int SPAWN_INTERVAL = 2,
  parameter int CW             = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          tick_i,
  input  logic [CW-1:0] bikes_i,
  output logic [N-1:0]  spawn_o,
  output logic          all_spawned_o
);

  localparam int IW = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL + 1) : 1;

  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] interval_q, interval_d;
  logic [N-1:0]  spawn_q, spawn_d;

  assign all_spawned_o = (count_q >= bikes_i);
  assign spawn_o       = spawn_q;

  // Next spawn count, interval and pulse; a due spawn waits one tick if the
  // previous pulse is still high so pulses are never back to back.
  always_comb begin
    count_d    = count_q;
    interval_d = interval_q;
    spawn_d    = '0;
    if (abort_i) begin
      count_d    = '0;
      interval_d = '0;
    end else if (start_i) begin
      spawn_d    = N'(1);
      count_d    = CW'(1);
      interval_d = '0;
    end else if (tick_i && !all_spawned_o) begin
      if (interval_q >= IW'(SPAWN_INTERVAL - 1)) begin
        if (spawn_q == '0) begin
          spawn_d    = N'(1) << count_q;
          count_d    = count_q + CW'(1);
          interval_d = '0;
        end
      end else begin
        interval_d = interval_q + IW'(1);
      end
    end
  end

  // Scheduler registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q    <= '0;
      interval_q <= '0;
      spawn_q    <= '0;
    end else begin
      count_q    <= count_d;
      interval_q <= interval_d;
      spawn_q    <= spawn_d;
    end
  end

endmodule

// File: rtl/level_director.sv
// Per-level sequencer: level number, enemy speed, level timer, score and
// game-over flag, with staggered enemy spawns delegated to spawn_scheduler.
//
// state       | meaning
// ST_IDLE     | welcome screen / no level loaded
// ST_ARMED    | level loaded, waiting for startOfMovement
// ST_SPAWNING | play running, enemies still being released
// ST_PLAYING  | play running, all enemies released
// ST_DONE     | level ended, waiting for loadLevel or startGame
module level_director
  import game_pkg::*;
#(
  parameter int ENEMY_BIKES_COUNT = DEFAULT_ENEMY_BIKES,
  parameter int MIN_BIKES         = 4,
  parameter int MAX_LEVEL         = 9,
  parameter int SPAWN_INTERVAL    = 2,
  parameter int BASE_SPEED        = 32,
  parameter int SPEED_STEP        = 8,
  parameter int LEVEL_BONUS       = 100,
  parameter int TIME_LIMIT        = 60
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         oneSec,
  input  logic                         startGame,
  input  logic                         loadLevel,
  input  logic                         startOfMovement,
  input  logic                         endLevel,
  input  logic [ENEMY_BIKES_COUNT:0]   bikersEnableVector,
  output logic [3:0]                   levelNum,
  output logic [7:0]                   enemySpeed,
  output logic [ENEMY_BIKES_COUNT-1:0] bikeSpawn,
  output logic [7:0]                   levelTime,
  output logic [15:0]                  score,
  output logic                         gameOver
);

  localparam int CW = $clog2(ENEMY_BIKES_COUNT + 1);

  level_state_t         state_q, state_d;
  logic [3:0]           level_q, level_d, level_next;
  logic [7:0]           speed_q, speed_d;
  logic [CW-1:0]        bikes_q, bikes_d;
  logic [7:0]           time_q, time_d;
  logic [SCORE_W-1:0]   score_q, score_d, score_cleared;
  logic                 over_q, over_d;
  logic                 spawn_start, spawn_abort, spawn_tick, all_spawned;
  logic                 player_alive;
  logic                 enemies_unused;
  int                   score_sum;

  function automatic logic [7:0] speed_for(input logic [3:0] lvl);
    int s;
    s = BASE_SPEED + (int'(lvl) - 1) * SPEED_STEP;
    if (s > 255) s = 255;
    return 8'(s);
  endfunction

  function automatic logic [CW-1:0] bikes_for(input logic [3:0] lvl);
    int b;
    b = MIN_BIKES + int'(lvl) - 1;
    if (b > ENEMY_BIKES_COUNT) b = ENEMY_BIKES_COUNT;
    return CW'(b);
  endfunction

  // Enemy alive bits are not needed here; only the player bit decides the outcome.
  assign enemies_unused = |bikersEnableVector[ENEMY_BIKES_COUNT-1:0];
  assign player_alive   = bikersEnableVector[ENEMY_BIKES_COUNT];
  assign level_next     = (level_q >= 4'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : level_q + 4'd1;

  // Score after a cleared level: fixed bonus plus unused seconds, saturating.
  always_comb begin
    score_sum = int'(score_q) + LEVEL_BONUS;
    if (TIME_LIMIT > int'(time_q)) score_sum = score_sum + TIME_LIMIT - int'(time_q);
    score_cleared = (score_sum > (1 << SCORE_W) - 1) ? '1 : SCORE_W'(score_sum);
  end

  // Next state and counters, honouring startGame > loadLevel > endLevel >
  // startOfMovement > oneSec.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    speed_d     = speed_q;
    bikes_d     = bikes_q;
    time_d      = time_q;
    score_d     = score_q;
    over_d      = over_q;
    spawn_start = 1'b0;
    spawn_abort = 1'b0;
    spawn_tick  = 1'b0;
    if (startGame) begin
      state_d     = ST_IDLE;
      level_d     = '0;
      time_d      = '0;
      score_d     = '0;
      over_d      = 1'b0;
      spawn_abort = 1'b1;
    end else if (loadLevel) begin
      state_d     = ST_ARMED;
      level_d     = level_next;
      speed_d     = speed_for(level_next);
      bikes_d     = bikes_for(level_next);
      time_d      = '0;
      spawn_abort = 1'b1;
    end else if (endLevel && (state_q == ST_SPAWNING || state_q == ST_PLAYING)) begin
      state_d     = ST_DONE;
      spawn_abort = 1'b1;
      if (!player_alive) over_d = 1'b1;
      else               score_d = score_cleared;
    end else if (startOfMovement && state_q == ST_ARMED) begin
      state_d     = ST_SPAWNING;
      spawn_start = 1'b1;
    end else if (oneSec && (state_q == ST_SPAWNING || state_q == ST_PLAYING)) begin
      if (time_q != 8'hFF) time_d = time_q + 8'd1;
      spawn_tick = (state_q == ST_SPAWNING);
    end
    if (state_q == ST_SPAWNING && state_d == ST_SPAWNING && all_spawned)
      state_d = ST_PLAYING;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      speed_q <= 8'(BASE_SPEED);
      bikes_q <= CW'(MIN_BIKES);
      time_q  <= '0;
      score_q <= '0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      speed_q <= speed_d;
      bikes_q <= bikes_d;
      time_q  <= time_d;
      score_q <= score_d;
      over_q  <= over_d;
    end
  end

  spawn_scheduler #(
    .N              (ENEMY_BIKES_COUNT),
    .SPAWN_INTERVAL (SPAWN_INTERVAL),
    .CW             (CW)
  ) u_spawn (
    .clk           (clk),
    .resetN        (resetN),
    .start_i       (spawn_start),
    .abort_i       (spawn_abort),
    .tick_i        (spawn_tick),
    .bikes_i       (bikes_q),
    .spawn_o       (bikeSpawn),
    .all_spawned_o (all_spawned)
  );

  assign levelNum   = level_q;
  assign enemySpeed = speed_q;
  assign levelTime  = time_q;
  assign score      = score_q;
  assign gameOver   = over_q;

endmodule

// File: tb/tb_level_director.sv
// Directed bench for level_director: a per-cycle vector table followed by
// hand-written multi-cycle sequences (spawn caps, aborts, timer, reset).
module tb_level_director;

  localparam logic [4:0] I_NONE = 5'b00000;
  localparam logic [4:0] I_SG   = 5'b10000;
  localparam logic [4:0] I_LL   = 5'b01000;
  localparam logic [4:0] I_SOM  = 5'b00100;
  localparam logic [4:0] I_EL   = 5'b00010;
  localparam logic [4:0] I_OS   = 5'b00001;
  localparam logic [16:0] P_ALIVE   = 17'h10000;
  localparam logic [16:0] ALL_ALIVE = 17'h1FFFF;
  localparam logic [16:0] ALL_DEAD  = 17'h00000;

  logic clk = 1'b0, resetN = 1'b0;
  logic oneSec = 1'b0, startGame = 1'b0, loadLevel = 1'b0;
  logic startOfMovement = 1'b0, endLevel = 1'b0;
  logic [16:0] bev = '0;

  logic [3:0]  levelNum,   levelNum_b;
  logic [7:0]  enemySpeed, enemySpeed_b;
  logic [15:0] bikeSpawn,  bikeSpawn_b;
  logic [7:0]  levelTime,  levelTime_b;
  logic [15:0] score,      score_b;
  logic        gameOver,   gameOver_b;

  int n_vec = 0, n_bad = 0;
  int cnt_a = 0, last_a = -1, cnt_b = 0, last_b = -1, prop_bad = 0;
  logic [15:0] prev_a = '0, prev_b = '0;

  always #5 clk = ~clk;

  level_director u_dut (
    .clk(clk), .resetN(resetN), .oneSec(oneSec), .startGame(startGame),
    .loadLevel(loadLevel), .startOfMovement(startOfMovement), .endLevel(endLevel),
    .bikersEnableVector(bev), .levelNum(levelNum), .enemySpeed(enemySpeed),
    .bikeSpawn(bikeSpawn), .levelTime(levelTime), .score(score), .gameOver(gameOver)
  );

  level_director #(.MIN_BIKES(10)) u_dut_b (
    .clk(clk), .resetN(resetN), .oneSec(oneSec), .startGame(startGame),
    .loadLevel(loadLevel), .startOfMovement(startOfMovement), .endLevel(endLevel),
    .bikersEnableVector(bev), .levelNum(levelNum_b), .enemySpeed(enemySpeed_b),
    .bikeSpawn(bikeSpawn_b), .levelTime(levelTime_b), .score(score_b), .gameOver(gameOver_b)
  );

  typedef struct {
    logic [4:0]  in;
    logic [16:0] bev;
    logic [3:0]  lvl;
    logic [7:0]  spd;
    logic [15:0] sp;
    logic [7:0]  tm;
    logic [15:0] sc;
    logic        go;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] in, input logic [16:0] b, input int lvl,
                              input int spd, input int sp, input int tm, input int sc, input int go);
    vec_t v;
    v.in = in; v.bev = b; v.lvl = 4'(lvl); v.spd = 8'(spd);
    v.sp = 16'(sp); v.tm = 8'(tm); v.sc = 16'(sc); v.go = go[0];
    return v;
  endfunction

  // One clock with the given strobes, then spawn bookkeeping for both DUTs.
  task automatic step(input logic [4:0] in);
    {startGame, loadLevel, startOfMovement, endLevel, oneSec} = in;
    @(posedge clk); #1;
    {startGame, loadLevel, startOfMovement, endLevel, oneSec} = I_NONE;
    if (bikeSpawn != '0) begin
      cnt_a++;
      for (int i = 0; i < 16; i++) if (bikeSpawn[i]) last_a = i;
      if ($countones(bikeSpawn) != 1 || prev_a != '0) prop_bad++;
    end
    if (bikeSpawn_b != '0) begin
      cnt_b++;
      for (int i = 0; i < 16; i++) if (bikeSpawn_b[i]) last_b = i;
      if ($countones(bikeSpawn_b) != 1 || prev_b != '0) prop_bad++;
    end
    prev_a = bikeSpawn;
    prev_b = bikeSpawn_b;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    cnt_a = 0; last_a = -1; cnt_b = 0; last_b = -1;
  endtask

  vec_t tbl[$];

  initial begin
    tbl.push_back(mk(I_SG,        ALL_DEAD,  0, 32, 0, 0,   0, 0));
    tbl.push_back(mk(I_NONE,      ALL_DEAD,  0, 32, 0, 0,   0, 0));
    tbl.push_back(mk(I_LL,        ALL_DEAD,  1, 32, 0, 0,   0, 0));
    tbl.push_back(mk(I_SOM,       ALL_DEAD,  1, 32, 1, 0,   0, 0));
    tbl.push_back(mk(I_OS,        ALL_DEAD,  1, 32, 0, 1,   0, 0));
    tbl.push_back(mk(I_OS,        ALL_DEAD,  1, 32, 2, 2,   0, 0));
    tbl.push_back(mk(I_NONE,      ALL_DEAD,  1, 32, 0, 2,   0, 0));
    tbl.push_back(mk(I_OS,        ALL_DEAD,  1, 32, 0, 3,   0, 0));
    tbl.push_back(mk(I_OS,        ALL_DEAD,  1, 32, 4, 4,   0, 0));
    tbl.push_back(mk(I_OS,        ALL_DEAD,  1, 32, 0, 5,   0, 0));
    tbl.push_back(mk(I_OS,        ALL_DEAD,  1, 32, 8, 6,   0, 0));
    tbl.push_back(mk(I_OS,        ALL_DEAD,  1, 32, 0, 7,   0, 0));
    tbl.push_back(mk(I_OS,        ALL_DEAD,  1, 32, 0, 8,   0, 0));
    tbl.push_back(mk(I_EL,        P_ALIVE,   1, 32, 0, 8, 152, 0));
    tbl.push_back(mk(I_EL,        ALL_ALIVE, 1, 32, 0, 8, 152, 0));
    tbl.push_back(mk(I_OS,        ALL_DEAD,  1, 32, 0, 8, 152, 0));
    tbl.push_back(mk(I_SG | I_LL, ALL_DEAD,  0, 32, 0, 0,   0, 0));
    tbl.push_back(mk(I_LL,        ALL_DEAD,  1, 32, 0, 0,   0, 0));
    tbl.push_back(mk(I_LL,        ALL_DEAD,  2, 40, 0, 0,   0, 0));
    tbl.push_back(mk(I_SOM,       ALL_DEAD,  2, 40, 1, 0,   0, 0));
    tbl.push_back(mk(I_EL | I_OS, ALL_DEAD,  2, 40, 0, 0,   0, 1));
    tbl.push_back(mk(I_LL,        ALL_DEAD,  3, 48, 0, 0,   0, 1));
    tbl.push_back(mk(I_EL,        P_ALIVE,   3, 48, 0, 0,   0, 1));
    tbl.push_back(mk(I_SOM | I_OS, ALL_DEAD, 3, 48, 1, 0,   0, 1));
    tbl.push_back(mk(I_OS,        ALL_DEAD,  3, 48, 0, 1,   0, 1));
    tbl.push_back(mk(I_OS,        ALL_DEAD,  3, 48, 2, 2,   0, 1));
    tbl.push_back(mk(I_SG,        ALL_DEAD,  0, 48, 0, 0,   0, 0));

    repeat (2) @(posedge clk);
    #1;
    chk("reset_level", int'(levelNum), 0);
    chk("reset_speed", int'(enemySpeed), 32);
    chk("reset_spawn", int'(bikeSpawn), 0);
    chk("reset_time",  int'(levelTime), 0);
    chk("reset_score", int'(score), 0);
    chk("reset_over",  int'(gameOver), 0);
    @(negedge clk);
    resetN = 1'b1;

    foreach (tbl[k]) begin
      bev = tbl[k].bev;
      step(tbl[k].in);
      n_vec++;
      if ({levelNum, enemySpeed, bikeSpawn, levelTime, score, gameOver} !==
          {tbl[k].lvl, tbl[k].spd, tbl[k].sp, tbl[k].tm, tbl[k].sc, tbl[k].go}) begin
        n_bad++;
        $display("FAIL vec%0d: got lvl=%0d spd=%0d spawn=%h time=%0d score=%0d over=%0d, want lvl=%0d spd=%0d spawn=%h time=%0d score=%0d over=%0d",
                 k, levelNum, enemySpeed, bikeSpawn, levelTime, score, gameOver,
                 tbl[k].lvl, tbl[k].spd, tbl[k].sp, tbl[k].tm, tbl[k].sc, tbl[k].go);
      end
    end

    // Time bonus: cleared at 20 s, then beyond the limit, then timer saturation.
    bev = P_ALIVE;
    step(I_LL); step(I_SOM);
    repeat (20) step(I_OS);
    chk("time_20", int'(levelTime), 20);
    step(I_EL);
    chk("score_140", int'(score), 140);
    step(I_LL); step(I_SOM);
    repeat (75) step(I_OS);
    chk("time_75", int'(levelTime), 75);
    step(I_EL);
    chk("score_240", int'(score), 240);
    step(I_LL); step(I_SOM);
    repeat (260) step(I_OS);
    chk("time_sat", int'(levelTime), 255);

    // Level and speed saturation; spawn count cap for both bike minimums.
    step(I_SG);
    repeat (12) step(I_LL);
    chk("level_sat", int'(levelNum), 9);
    chk("speed_lvl9", int'(enemySpeed), 96);
    clear_stats();
    step(I_SOM);
    repeat (40) step(I_OS);
    chk("spawns_lvl9", cnt_a, 12);
    chk("last_spawn_lvl9", last_a, 11);
    chk("spawns_cap16", cnt_b, 16);
    chk("last_spawn_cap16", last_b, 15);

    // loadLevel in the middle of spawning aborts the old level.
    step(I_SG); step(I_LL);
    clear_stats();
    step(I_SOM); step(I_OS); step(I_OS);
    chk("abort_pre_spawns", cnt_a, 2);
    chk("abort_pre_last", last_a, 1);
    step(I_LL);
    chk("abort_level", int'(levelNum), 2);
    chk("abort_time", int'(levelTime), 0);
    repeat (6) step(I_OS);
    chk("abort_no_spawn", cnt_a, 2);
    chk("armed_time", int'(levelTime), 0);
    step(I_SOM);
    chk("restart_bit0", int'(bikeSpawn), 1);

    // Asynchronous reset in the middle of a level, right on a spawn pulse.
    step(I_SG); step(I_LL); step(I_SOM); step(I_OS); step(I_OS);
    #2 resetN = 1'b0;
    #1;
    chk("async_spawn", int'(bikeSpawn), 0);
    chk("async_level", int'(levelNum), 0);
    chk("async_time",  int'(levelTime), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    clear_stats();
    repeat (4) step(I_OS);
    chk("post_reset_spawns", cnt_a, 0);
    step(I_LL);
    chk("post_reset_level", int'(levelNum), 1);

    chk("spawn_onehot_gap", prop_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
